// File: rtl/memwb.sv
// Memory/writeback stage: ALU results retire in one cycle, loads and stores hold a request on the bus.
// Optional feature: define MEMWB_BUS_TIMEOUT_EN to abort unacknowledged bus accesses after 255 cycles.

`ifndef RW
`define RW 16
`endif
`ifndef REGNO
`define REGNO 8
`endif

module memwb (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_submit,
    output logic              o_ready,
    input  logic [`RW-1:0]    i_data,
    input  logic [`RW-1:0]    i_addr,
    input  logic [`REGNO-1:0] i_reg_ie,
    input  logic              i_mem_access,
    input  logic              i_mem_we,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [`RW-1:0]    o_mem_addr,
    output logic [`RW-1:0]    o_mem_data,
    input  logic              i_mem_ack,
    input  logic [`RW-1:0]    i_mem_data,
    output logic [`REGNO-1:0] o_reg_ie,
    output logic [`RW-1:0]    o_reg_data,
    output logic              o_bus_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t            state_r;
    logic [`REGNO-1:0] load_reg_ie_r;
    logic              accept_s;
    logic              accept_mem_s;
    logic              accept_alu_s;
    logic              ack_s;
    logic              timeout_s;

    assign o_ready      = (state_r == IDLE);
    assign accept_s     = i_submit & o_ready;
    assign accept_mem_s = accept_s & i_mem_access;
    assign accept_alu_s = accept_s & ~i_mem_access;
    // An ack only counts while a request is actually outstanding.
    assign ack_s        = (state_r == BUS) & o_mem_req & i_mem_ack;

`ifdef MEMWB_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;

    logic [7:0] bus_cnt_r;

    // The 255th unacknowledged BUS cycle ends the access.
    assign timeout_s = (state_r == BUS) & ~ack_s & (bus_cnt_r == TIMEOUT_LAST);

    // Cycles spent waiting in BUS, restarted for each new access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus_cnt_r <= 8'd0;
        end else if (accept_mem_s) begin
            bus_cnt_r <= 8'd0;
        end else if ((state_r == BUS) && !ack_s && !timeout_s) begin
            bus_cnt_r <= bus_cnt_r + 8'd1;
        end else begin
            bus_cnt_r <= bus_cnt_r;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bus_err <= 1'b0;
        end else if (timeout_s) begin
            o_bus_err <= 1'b1;
        end else begin
            o_bus_err <= o_bus_err;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // Control FSM with its registered request and writeback-enable outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= IDLE;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_reg_ie      <= {`REGNO{1'b0}};
            load_reg_ie_r <= {`REGNO{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_mem_s) begin
                        state_r       <= BUS;
                        o_mem_req     <= 1'b1;
                        o_mem_we      <= i_mem_we;
                        o_reg_ie      <= {`REGNO{1'b0}};
                        load_reg_ie_r <= i_reg_ie;
                    end else if (accept_alu_s) begin
                        state_r       <= IDLE;
                        o_mem_req     <= 1'b0;
                        o_mem_we      <= 1'b0;
                        o_reg_ie      <= i_reg_ie;
                        load_reg_ie_r <= load_reg_ie_r;
                    end else begin
                        state_r       <= IDLE;
                        o_mem_req     <= 1'b0;
                        o_mem_we      <= 1'b0;
                        o_reg_ie      <= {`REGNO{1'b0}};
                        load_reg_ie_r <= load_reg_ie_r;
                    end
                end
                BUS: begin
                    if (ack_s) begin
                        state_r       <= IDLE;
                        o_mem_req     <= 1'b0;
                        o_mem_we      <= 1'b0;
                        // Stores retire without touching the register file.
                        o_reg_ie      <= o_mem_we ? {`REGNO{1'b0}} : load_reg_ie_r;
                        load_reg_ie_r <= load_reg_ie_r;
                    end else if (timeout_s) begin
                        state_r       <= IDLE;
                        o_mem_req     <= 1'b0;
                        o_mem_we      <= 1'b0;
                        o_reg_ie      <= {`REGNO{1'b0}};
                        load_reg_ie_r <= load_reg_ie_r;
                    end else begin
                        state_r       <= BUS;
                        o_mem_req     <= o_mem_req;
                        o_mem_we      <= o_mem_we;
                        o_reg_ie      <= {`REGNO{1'b0}};
                        load_reg_ie_r <= load_reg_ie_r;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    o_mem_req     <= 1'b0;
                    o_mem_we      <= 1'b0;
                    o_reg_ie      <= {`REGNO{1'b0}};
                    load_reg_ie_r <= {`REGNO{1'b0}};
                end
            endcase
        end
    end

    // Unreset datapath: bus address/data captured on acceptance, writeback data per retirement.
    always_ff @(posedge i_clk) begin
        if (accept_mem_s) begin
            o_mem_addr <= i_addr;
            o_mem_data <= i_data;
        end else begin
            o_mem_addr <= o_mem_addr;
            o_mem_data <= o_mem_data;
        end

        if (accept_alu_s) begin
            o_reg_data <= i_data;
        end else if (ack_s) begin
            o_reg_data <= i_mem_data;
        end else begin
            o_reg_data <= o_reg_data;
        end
    end

endmodule

// File: tb/tb_memwb.sv
// Self-checking bench for memwb: ALU vector table, scoreboard of expected writebacks, bus corner sequences.

module tb_memwb;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_submit;
    logic        o_ready;
    logic [15:0] i_data;
    logic [15:0] i_addr;
    logic [7:0]  i_reg_ie;
    logic        i_mem_access;
    logic        i_mem_we;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_data;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    logic [7:0]  o_reg_ie;
    logic [15:0] o_reg_data;
    logic        o_bus_err;

    memwb dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_submit     (i_submit),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_addr       (i_addr),
        .i_reg_ie     (i_reg_ie),
        .i_mem_access (i_mem_access),
        .i_mem_we     (i_mem_we),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .i_mem_ack    (i_mem_ack),
        .i_mem_data   (i_mem_data),
        .o_reg_ie     (o_reg_ie),
        .o_reg_data   (o_reg_data),
        .o_bus_err    (o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ie;
        logic [15:0] data;
        int          cyc;
    } wb_t;

    typedef struct {
        logic [7:0]  reg_ie;
        logic [15:0] data;
        logic        exp_wb;
        logic [7:0]  exp_ie;
        logic [15:0] exp_data;
    } vec_t;

    wb_t  sbq[$];
    wb_t  mon_e;
    vec_t vt[6];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Writeback scoreboard and bus-strobe sanity, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                mon_e = sbq.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL wb_missing: got nothing by cycle %0d, required ie=%h data=%h at cycle %0d",
                         cyc, mon_e.ie, mon_e.data, mon_e.cyc);
            end
            if (o_reg_ie !== 8'h00) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_unexpected: got ie=%h data=%h at cycle %0d, required no writeback",
                             o_reg_ie, o_reg_data, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    if (o_reg_ie !== mon_e.ie || o_reg_data !== mon_e.data || cyc != mon_e.cyc) begin
                        n_err++;
                        $display("FAIL wb_compare: got ie=%h data=%h cycle %0d, required ie=%h data=%h cycle %0d",
                                 o_reg_ie, o_reg_data, cyc, mon_e.ie, mon_e.data, mon_e.cyc);
                    end
                end
            end
            n_vec++;
            if (!o_mem_req && o_mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL we_without_req: got o_mem_we=%b, required 0 (cycle %0d)", o_mem_we, cyc);
            end
        end
    end

    task automatic submit(input logic acc, input logic we, input logic [15:0] addr,
                          input logic [15:0] data, input logic [7:0] ie);
        i_submit     = 1'b1;
        i_mem_access = acc;
        i_mem_we     = we;
        i_addr       = addr;
        i_data       = data;
        i_reg_ie     = ie;
        if (!acc && ie != 8'h00) sbq.push_back('{ie, data, cyc + 1});
        @(posedge clk); #1;
        i_submit = 1'b0;
    endtask

    // Holds the bus for n cycles, acking in the last; junk submits meanwhile must be ignored.
    task automatic bus_wait(input int n, input logic is_load, input logic [7:0] ie,
                            input logic [15:0] rdata, input logic exp_we,
                            input logic [15:0] exp_addr, input logic [15:0] exp_wdata);
        for (int k = 1; k <= n; k++) begin
            if (k == n) begin
                i_submit   = 1'b0;
                i_mem_ack  = 1'b1;
                i_mem_data = rdata;
                if (is_load) sbq.push_back('{ie, rdata, cyc + 1});
            end else begin
                i_submit     = 1'b1;
                i_mem_access = 1'b0;
                i_reg_ie     = 8'h40;
                i_data       = 16'hDEAD;
                i_addr       = 16'hFFFF;
                i_mem_ack    = 1'b0;
            end
            @(negedge clk);
            chk("bus_req",   {31'd0, o_mem_req}, 32'd1);
            chk("bus_ready", {31'd0, o_ready},   32'd0);
            chk("bus_we",    {31'd0, o_mem_we},  {31'd0, exp_we});
            chk("bus_addr",  {16'd0, o_mem_addr}, {16'd0, exp_addr});
            chk("bus_wdata", {16'd0, o_mem_data}, {16'd0, exp_wdata});
            @(posedge clk); #1;
        end
        i_mem_ack = 1'b0;
        i_submit  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_cycles;

        vt[0] = '{8'h01, 16'h1234, 1'b1, 8'h01, 16'h1234};
        vt[1] = '{8'h02, 16'h5678, 1'b1, 8'h02, 16'h5678};
        vt[2] = '{8'h80, 16'hFFFF, 1'b1, 8'h80, 16'hFFFF};
        vt[3] = '{8'h00, 16'hA5A5, 1'b0, 8'h00, 16'h0000};
        vt[4] = '{8'h10, 16'h0001, 1'b1, 8'h10, 16'h0001};
        vt[5] = '{8'h08, 16'h0000, 1'b1, 8'h08, 16'h0000};

        i_rst = 1'b1; i_submit = 1'b0; i_data = 16'h0000; i_addr = 16'h0000;
        i_reg_ie = 8'h00; i_mem_access = 1'b0; i_mem_we = 1'b0;
        i_mem_ack = 1'b0; i_mem_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",   {31'd0, o_ready},   32'd1);
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_mem_we",  {31'd0, o_mem_we},  32'd0);
        chk("rst_reg_ie",  {24'd0, o_reg_ie},  32'd0);
        chk("rst_bus_err", {31'd0, o_bus_err}, 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Back-to-back ALU instructions from the table.
        for (int i = 0; i < 6; i++) begin
            i_submit = 1'b1; i_mem_access = 1'b0; i_mem_we = 1'b0;
            i_reg_ie = vt[i].reg_ie; i_data = vt[i].data; i_addr = 16'h0000;
            if (vt[i].exp_wb) sbq.push_back('{vt[i].exp_ie, vt[i].exp_data, cyc + 1});
            @(negedge clk);
            chk("alu_ready", {31'd0, o_ready}, 32'd1);
            @(posedge clk); #1;
        end
        i_submit = 1'b0;

        // Ack with no request outstanding must do nothing.
        i_mem_ack = 1'b1; i_mem_data = 16'h1111;
        @(negedge clk);
        chk("idle_ack_req", {31'd0, o_mem_req}, 32'd0);
        @(posedge clk); #1;
        i_mem_ack = 1'b0;

        // Load acked in its third bus cycle.
        submit(1'b1, 1'b0, 16'h0040, 16'h9999, 8'h04);
        bus_wait(3, 1'b1, 8'h04, 16'hBEEF, 1'b0, 16'h0040, 16'h9999);
        @(negedge clk);
        chk("load_done_req",   {31'd0, o_mem_req}, 32'd0);
        chk("load_done_ready", {31'd0, o_ready},   32'd1);
        @(posedge clk); #1;

        // Store acked immediately.
        submit(1'b1, 1'b1, 16'h0010, 16'hAAAA, 8'h08);
        bus_wait(1, 1'b0, 8'h00, 16'h7777, 1'b1, 16'h0010, 16'hAAAA);
        @(negedge clk);
        chk("store_done_req", {31'd0, o_mem_req}, 32'd0);
        chk("store_reg_ie",   {24'd0, o_reg_ie},  32'd0);
        @(posedge clk); #1;

        // Reset while a load is outstanding; the late ack must be dropped.
        submit(1'b1, 1'b0, 16'h0020, 16'h0000, 8'h20);
        i_rst = 1'b1;
        @(negedge clk);
        chk("rbus_req_before", {31'd0, o_mem_req}, 32'd1);
        @(posedge clk); #1;
        i_rst = 1'b0; i_mem_ack = 1'b1; i_mem_data = 16'h5555;
        @(negedge clk);
        chk("rbus_req",    {31'd0, o_mem_req}, 32'd0);
        chk("rbus_ready",  {31'd0, o_ready},   32'd1);
        chk("rbus_reg_ie", {24'd0, o_reg_ie},  32'd0);
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk("rbus_no_wb", {24'd0, o_reg_ie}, 32'd0);
        chk("rbus_ready2", {31'd0, o_ready}, 32'd1);
        @(posedge clk); #1;

        // Load that is never acknowledged.
        submit(1'b1, 1'b0, 16'h0100, 16'h0000, 8'h01);
        req_cycles = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!o_mem_req) break;
            req_cycles++;
            @(posedge clk); #1;
        end
`ifdef MEMWB_BUS_TIMEOUT_EN
        chk("to_req_cycles", req_cycles, 32'd255);
        chk("to_bus_err",    {31'd0, o_bus_err}, 32'd1);
        chk("to_ready",      {31'd0, o_ready},   32'd1);
        chk("to_no_wb",      {24'd0, o_reg_ie},  32'd0);
        @(posedge clk); #1;
`else
        chk("nto_req_cycles", req_cycles, 32'd300);
        chk("nto_bus_err",    {31'd0, o_bus_err}, 32'd0);
        bus_wait(1, 1'b1, 8'h01, 16'hC0DE, 1'b0, 16'h0100, 16'h0000);
`endif
        submit(1'b0, 1'b0, 16'h0000, 16'h4242, 8'h02);
        @(negedge clk);
        chk("after_reg_ie", {24'd0, o_reg_ie}, 32'h02);
`ifdef MEMWB_BUS_TIMEOUT_EN
        chk("to_err_sticky", {31'd0, o_bus_err}, 32'd1);
`else
        chk("nto_err_zero", {31'd0, o_bus_err}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
